// File: rtl/noc_input_buffer.sv
// Router input FIFO: show-ahead head flit, 1-cycle write-to-read latency (no fall-through).
// Back-pressures upstream with ret while full; records overflow/underflow attempts in sticky flags.
module noc_input_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int ADDR_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  val,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic                  ret,
  output logic                  empty,
  input  logic                  read,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf_err,
  output logic                  udf_err
);

  localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH-1:0];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH-1:0];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  ovf_err_q, ovf_err_d;
  logic                  udf_err_q, udf_err_d;
  logic                  push, pop;

  // Outputs depend on registered state only, never on val/read/data_in.
  assign empty    = (count_q == '0);
  assign ret      = (count_q == FULL_CNT);
  assign data_out = mem_q[rd_ptr_q];
  assign count    = count_q;
  assign ovf_err  = ovf_err_q;
  assign udf_err  = udf_err_q;

  always_comb begin
    push      = val & ~ret;
    pop       = read & ~empty;
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_err_d = ovf_err_q | (val & ret);
    udf_err_d = udf_err_q | (read & empty);

    if (push) begin
      mem_d[wr_ptr_q] = data_in;
      wr_ptr_d        = wr_ptr_q + ADDR_WIDTH'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (ADDR_WIDTH+1)'(1);
      2'b01:   count_d = count_q - (ADDR_WIDTH+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset; only the control state is cleared.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

endmodule

// File: tb/tb_noc_input_buffer.sv
// Bench for noc_input_buffer: queue-based reference model checked every cycle, plus directed literal checks.
module tb_noc_input_buffer;

  localparam int DW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic          clk;
  logic          rst_n;
  logic          val;
  logic [DW-1:0] data_in;
  logic          ret;
  logic          empty;
  logic          read;
  logic [DW-1:0] data_out;
  logic [AW:0]   count;
  logic          ovf_err;
  logic          udf_err;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] mq[$];
  logic          m_ovf;
  logic          m_udf;

  noc_input_buffer #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .val      (val),
    .data_in  (data_in),
    .ret      (ret),
    .empty    (empty),
    .read     (read),
    .data_out (data_out),
    .count    (count),
    .ovf_err  (ovf_err),
    .udf_err  (udf_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue, updated with the same edge the DUT sees.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      automatic bit was_full  = (mq.size() == DEPTH);
      automatic bit was_empty = (mq.size() == 0);
      if (val && was_full)   m_ovf = 1'b1;
      if (read && was_empty) m_udf = 1'b1;
      if (read && !was_empty) void'(mq.pop_front());
      if (val && !was_full)  mq.push_back(data_in);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("count",   64'(count),   64'(mq.size()));
      check("empty",   64'(empty),   64'(mq.size() == 0));
      check("ret",     64'(ret),     64'(mq.size() == DEPTH));
      check("ovf_err", 64'(ovf_err), 64'(m_ovf));
      check("udf_err", 64'(udf_err), 64'(m_udf));
      if (mq.size() != 0) check("data_out", 64'(data_out), 64'(mq[0]));
    end
  end

  task automatic step(input logic v, input logic [DW-1:0] d, input logic r);
    val     = v;
    data_in = d;
    read    = r;
    @(negedge clk);
    val  = 1'b0;
    read = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    val     = 1'b0;
    read    = 1'b0;
    data_in = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Set udf and hold two flits, then reset asynchronously mid-cycle.
    step(1'b0, 32'h0, 1'b1);
    step(1'b1, 32'h11, 1'b0);
    step(1'b1, 32'h12, 1'b0);
    check("pre_rst_udf", 64'(udf_err), 64'h1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_empty", 64'(empty),   64'h1);
    check("arst_ret",   64'(ret),     64'h0);
    check("arst_count", 64'(count),   64'h0);
    check("arst_ovf",   64'(ovf_err), 64'h0);
    check("arst_udf",   64'(udf_err), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Fill and drain.
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA1 + i, 1'b0);
    check("fill_count", 64'(count), 64'h4);
    check("fill_ret",   64'(ret),   64'h1);
    check("model_size", 64'(mq.size()), 64'h4);
    for (int i = 0; i < 4; i++) begin
      check("drain_data", 64'(data_out), 64'hA1 + i);
      step(1'b0, 32'h0, 1'b1);
      if (i == 0) check("drain_ret", 64'(ret), 64'h0);
    end
    check("drain_empty", 64'(empty), 64'h1);

    // Wrap-around.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h10 + i, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + i, 1'b0);
    for (int i = 0; i < 4; i++) begin
      check("wrap_data", 64'(data_out), 64'hB0 + i);
      step(1'b0, 32'h0, 1'b1);
    end
    check("wrap_count", 64'(count), 64'h0);

    // Simultaneous push/pop at count 2.
    step(1'b1, 32'h20, 1'b0);
    step(1'b1, 32'h21, 1'b0);
    for (int i = 0; i < 10; i++) begin
      check("sim_data", 64'(data_out), 64'h20 + i);
      step(1'b1, 32'h22 + i, 1'b1);
      check("sim_count", 64'(count), 64'h2);
    end
    step(1'b0, 32'h0, 1'b1);
    step(1'b0, 32'h0, 1'b1);

    // Overflow then underflow.
    for (int i = 0; i < 4; i++) step(1'b1, 32'h30 + i, 1'b0);
    step(1'b1, 32'hFF, 1'b0);
    check("ovf_flag",  64'(ovf_err), 64'h1);
    check("ovf_count", 64'(count),   64'h4);
    for (int i = 0; i < 4; i++) begin
      check("ovf_data", 64'(data_out), 64'h30 + i);
      step(1'b0, 32'h0, 1'b1);
    end
    step(1'b0, 32'h0, 1'b1);
    check("udf_flag",  64'(udf_err), 64'h1);
    check("udf_count", 64'(count),   64'h0);
    repeat (3) step(1'b0, 32'h0, 1'b0);
    check("ovf_sticky", 64'(ovf_err), 64'h1);
    check("udf_sticky", 64'(udf_err), 64'h1);

    // Reset with three flits stored.
    for (int i = 0; i < 3; i++) step(1'b1, 32'h40 + i, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mrst_empty", 64'(empty), 64'h1);
    check("mrst_count", 64'(count), 64'h0);
    rst_n = 1'b1;
    step(1'b1, 32'hC5, 1'b0);
    check("mrst_data",  64'(data_out), 64'hC5);
    check("mrst_cnt1",  64'(count),    64'h1);
    step(1'b0, 32'h0, 1'b1);
    check("mrst_empty2", 64'(empty), 64'h1);

    // Randomized traffic with phases biased toward full and toward empty.
    for (int i = 0; i < 3000; i++) begin
      automatic int phase = (i / 200) % 3;
      automatic logic v, r;
      case (phase)
        0:       begin v = ($urandom_range(0, 3) != 0); r = ($urandom_range(0, 3) == 0); end
        1:       begin v = ($urandom_range(0, 3) == 0); r = ($urandom_range(0, 3) != 0); end
        default: begin v = $urandom_range(0, 1) != 0;   r = $urandom_range(0, 1) != 0;   end
      endcase
      step(v, 32'($urandom), r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
